bcd_display_scanner: RTL and testbench

Consumes the four 5-bit BCD digit buses produced by the reaction-timer BCD counter and drives a time-multiplexed 4-digit common-anode seven-segment display. It snapshots the digits on command, scans one digit per refresh slot with anti-ghosting guard cycles, and supports leading-zero blanking, a fixed decimal point, invalid-digit flagging and whole-display blinking. It sits between the counter and the board display pins.

---
 rtl/bcd_display_scanner_if.sv | 25 ++
 rtl/bcd_display_scanner.sv | 145 ++++++++++++++
 tb/tb_bcd_display_scanner.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_scanner_if.sv
// Pin-level bundle between the BCD counter / board display and the scanner.
interface bcd_display_scanner_if;
  logic       Load;
  logic [4:0] BCD3;
  logic [4:0] BCD2;
  logic [4:0] BCD1;
  logic [4:0] BCD0;
  logic       Blank_Lead;
  logic       Blink;
  logic [6:0] Seg;
  logic       DP;
  logic [3:0] Anode;
  logic       Frame_Done;
  logic       Invalid;

  modport master (
    output Load, BCD3, BCD2, BCD1, BCD0, Blank_Lead, Blink,
    input  Seg, DP, Anode, Frame_Done, Invalid
  );

  modport slave (
    input  Load, BCD3, BCD2, BCD1, BCD0, Blank_Lead, Blink,
    output Seg, DP, Anode, Frame_Done, Invalid
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit seven-segment driver: snapshots BCD digits on Load,
// scans one digit per refresh slot with leading guard cycles, and supports
// leading-zero blanking, a fixed decimal point, invalid flagging and blinking.
module bcd_display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 2,
  parameter int unsigned BLINK_DIV   = 64,
  parameter int unsigned DP_POS      = 3,
  parameter bit          ACTIVE_LOW  = 1
) (
  input logic                  Clock,
  input logic                  Reset,
  bcd_display_scanner_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);
  localparam logic [1:0]       DP_IDX    = 2'(DP_POS);

  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [3:0] AN_OFF  = {4{ACTIVE_LOW}};
  localparam logic       DP_OFF  = ACTIVE_LOW;

  typedef enum logic {PH_ON, PH_OFF} phase_t;

  logic [3:0][4:0]  snap_q, snap_d;
  logic             invalid_q, invalid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  phase_t           phase_q, phase_d;
  logic             frame_done_q, frame_done_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       anode_q, anode_d;

  // Active-high {g,f,e,d,c,b,a} pattern; anything above 9 shows "E".
  function automatic logic [6:0] seg_map(input logic [4:0] d);
    case (d)
      5'd0:    seg_map = 7'h3F;
      5'd1:    seg_map = 7'h06;
      5'd2:    seg_map = 7'h5B;
      5'd3:    seg_map = 7'h4F;
      5'd4:    seg_map = 7'h66;
      5'd5:    seg_map = 7'h6D;
      5'd6:    seg_map = 7'h7D;
      5'd7:    seg_map = 7'h07;
      5'd8:    seg_map = 7'h7F;
      5'd9:    seg_map = 7'h6F;
      default: seg_map = 7'h79;
    endcase
  endfunction

  // Next-state logic for snapshot, scan position, blink and registered pins.
  always_comb begin
    logic       last_slot;
    logic       anode_on;
    logic       lead_blank;
    logic [6:0] seg_raw;
    logic [3:0] an_raw;
    logic       dp_raw;

    snap_d    = snap_q;
    invalid_d = invalid_q;
    if (bus.Load) begin
      snap_d    = {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0};
      invalid_d = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (snap_d[i] > 5'd9) invalid_d = 1'b1;
      end
    end

    last_slot    = (cnt_q == CNT_LAST);
    cnt_d        = last_slot ? '0 : cnt_q + 1'b1;
    idx_d        = last_slot ? idx_q + 2'd1 : idx_q;
    frame_done_d = last_slot && (idx_q == 2'd3);

    blk_d   = blk_q;
    phase_d = phase_q;
    if (!bus.Blink) begin
      blk_d   = '0;
      phase_d = PH_ON;
    end else if (frame_done_q) begin
      if (blk_q == BLK_LAST) begin
        blk_d   = '0;
        phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end

    // A digit is blanked when it and every more-significant digit are zero.
    lead_blank = bus.Blank_Lead && (idx_q != 2'd0);
    for (int unsigned j = 0; j < 4; j++) begin
      if ((j >= 32'(idx_q)) && (snap_q[j] != 5'd0)) lead_blank = 1'b0;
    end

    anode_on = (cnt_q >= CNT_GUARD) && ((phase_q == PH_ON) || !bus.Blink);
    an_raw   = anode_on ? (4'b0001 << idx_q) : 4'b0000;
    dp_raw   = anode_on && (idx_q == DP_IDX);
    seg_raw  = (anode_on && !lead_blank) ? seg_map(snap_q[idx_q]) : 7'h00;

    seg_d   = ACTIVE_LOW ? ~seg_raw : seg_raw;
    anode_d = ACTIVE_LOW ? ~an_raw  : an_raw;
    dp_d    = ACTIVE_LOW ? ~dp_raw  : dp_raw;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      snap_q       <= '0;
      invalid_q    <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      blk_q        <= '0;
      phase_q      <= PH_ON;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      anode_q      <= AN_OFF;
    end else begin
      snap_q       <= snap_d;
      invalid_q    <= invalid_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blk_q        <= blk_d;
      phase_q      <= phase_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      anode_q      <= anode_d;
    end
  end

  assign bus.Seg        = seg_q;
  assign bus.DP         = dp_q;
  assign bus.Anode      = anode_q;
  assign bus.Frame_Done = frame_done_q;
  assign bus.Invalid    = invalid_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner (REFRESH_DIV=4, GUARD=1,
// BLINK_DIV=2, DP_POS=3, active-high pins).
module tb_bcd_display_scanner;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  always #5 Clock = ~Clock;

  bcd_display_scanner_if bus();

  bcd_display_scanner #(
    .REFRESH_DIV(4),
    .GUARD      (1),
    .BLINK_DIV  (2),
    .DP_POS     (3),
    .ACTIVE_LOW (0)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Expected displayed digit: {Anode, Seg, DP}, pushed by stimulus.
  logic [11:0] exp_q[$];
  bit          scan_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [11:0] ent(input int unsigned d, input logic [6:0] seg);
    logic [3:0] an;
    an  = 4'(1 << d);
    ent = {an, seg, (d == 3)};
  endfunction

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    exp_q.push_back(ent(0, s0));
    exp_q.push_back(ent(1, s1));
    exp_q.push_back(ent(2, s2));
    exp_q.push_back(ent(3, s3));
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_anode"}, 32'(bus.Anode),      32'h0);
    chk({tag, "_seg"},   32'(bus.Seg),        32'h0);
    chk({tag, "_dp"},    32'(bus.DP),         32'h0);
    chk({tag, "_fd"},    32'(bus.Frame_Done), 32'h0);
    chk({tag, "_inv"},   32'(bus.Invalid),    32'h0);
  endtask

  // Reset edge (E0), Load on E1; returns just after the negedge following E1.
  task automatic scn_begin(input logic [4:0] d3, input logic [4:0] d2,
                           input logic [4:0] d1, input logic [4:0] d0,
                           input bit blank, input bit blink, input bit want_inv,
                           input bit guard_chk);
    Reset          = 1'b1;
    bus.Load       = 1'b0;
    bus.Blank_Lead = blank;
    bus.Blink      = blink;
    @(posedge Clock);
    @(negedge Clock);
    chk_reset("reset");
    #1;
    Reset    = 1'b0;
    bus.Load = 1'b1;
    bus.BCD3 = d3;
    bus.BCD2 = d2;
    bus.BCD1 = d1;
    bus.BCD0 = d0;
    @(posedge Clock);
    #1;
    bus.Load = 1'b0;
    @(negedge Clock);
    chk("first_guard_anode", 32'(bus.Anode), 32'h0);
    chk("invalid_after_load", 32'(bus.Invalid), 32'(want_inv));
    #1;
    scan_chk = guard_chk;
  endtask

  task automatic scn_end(input int unsigned n);
    tick(n);
    @(negedge Clock);
    #1;
    scan_chk = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
  endtask

  // Monitor: each time a digit lights up, compare against the scoreboard.
  logic [3:0] prev_an = 4'h0;
  logic       prev_on = 1'b0;
  bit         seen_on = 1'b0;
  int         on_run  = 0;
  int         off_run = 0;
  logic [11:0] e;

  always @(negedge Clock) begin
    if (bus.Anode != 4'h0 && prev_an == 4'h0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_digit got=%0h want=none at %0t",
                 {bus.Anode, bus.Seg, bus.DP}, $time);
      end else begin
        e = exp_q.pop_front();
        chk("digit", 32'({bus.Anode, bus.Seg, bus.DP}), 32'(e));
      end
    end
    prev_an = bus.Anode;

    if (!scan_chk) begin
      on_run  = 0;
      off_run = 0;
      seen_on = 1'b0;
    end else if (bus.Anode != 4'h0) begin
      if (!prev_on) begin
        if (seen_on) chk("guard_len", 32'(off_run), 32'd1);
        on_run = 0;
      end
      on_run++;
      seen_on = 1'b1;
    end else begin
      if (prev_on) begin
        if (seen_on) chk("lit_len", 32'(on_run), 32'd3);
        off_run = 0;
      end
      off_run++;
    end
    prev_on = (bus.Anode != 4'h0);
  end

  // Frame_Done must arrive every 16 cycles, counted from the reset edge.
  int cyc      = 0;
  int last_evt = 0;

  always @(posedge Clock) begin
    cyc++;
    if (Reset) last_evt = cyc;
  end

  always @(negedge Clock) begin
    if (bus.Frame_Done === 1'b1) begin
      chk("frame_period", 32'(cyc - last_evt), 32'd16);
      last_evt = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Load       = 1'b0;
    bus.BCD3       = '0;
    bus.BCD2       = '0;
    bus.BCD1       = '0;
    bus.BCD0       = '0;
    bus.Blank_Lead = 1'b0;
    bus.Blink      = 1'b0;
    tick(2);

    // 1,2,3,4: plain scan, two frames.
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06);
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06);
    scn_begin(5'd1, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    scn_end(32);

    // 0,0,0,7 with leading-zero blanking.
    push_frame(7'h07, 7'h00, 7'h00, 7'h00);
    scn_begin(5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    scn_end(16);

    // All zero with blanking: digit 0 still shows 0.
    push_frame(7'h3F, 7'h00, 7'h00, 7'h00);
    scn_begin(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    scn_end(16);

    // Invalid digit 1, then a valid reload on the slot-change edge (E16).
    push_frame(7'h3F, 7'h79, 7'h3F, 7'h3F);
    push_frame(7'h6D, 7'h7D, 7'h7F, 7'h6F);
    scn_begin(5'd0, 5'd0, 5'd12, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(14);
    bus.Load = 1'b1;
    bus.BCD3 = 5'd9;
    bus.BCD2 = 5'd8;
    bus.BCD1 = 5'd6;
    bus.BCD0 = 5'd5;
    tick(1);
    bus.Load = 1'b0;
    bus.BCD1 = 5'd12;
    @(negedge Clock);
    chk("invalid_cleared", 32'(bus.Invalid), 32'h0);
    #1;
    scn_end(17);

    // Blink: frames 0,1 lit, frame 2 dark until Blink drops at slot 2 (E40).
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06);
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06);
    exp_q.push_back(ent(2, 7'h5B));
    exp_q.push_back(ent(3, 7'h06));
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06);
    scn_begin(5'd1, 5'd2, 5'd3, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(35);
    @(negedge Clock);
    chk("blink_off_anode", 32'(bus.Anode), 32'h0);
    #1;
    tick(4);
    bus.Blink = 1'b0;
    scn_end(25);

    // Reset at idx=2, cnt=2; snapshot clears so the restart shows zeros.
    exp_q.push_back(ent(0, 7'h79));
    exp_q.push_back(ent(1, 7'h4F));
    exp_q.push_back(ent(2, 7'h5B));
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);
    scn_begin(5'd1, 5'd2, 5'd3, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(9);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    @(negedge Clock);
    chk_reset("midscan_reset");
    #1;
    scn_end(17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
